// File: rtl/pr_shutdown_ctrl.sv
// PR shutdown sequencer: fans one PR shutdown request out to per-channel stages,
// gathers their acks, then decouples; on release, un-decouples before dropping requests.
module pr_shutdown_ctrl #(
    parameter int C_NUM_CHANNELS   = 4,
    parameter int C_TIMEOUT_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_pr_shutdown_req,
    output logic                      o_pr_shutdown_ack,
    output logic                      o_pr_decouple,
    input  logic [C_NUM_CHANNELS-1:0] i_channel_mask,
    output logic [C_NUM_CHANNELS-1:0] o_channel_req,
    input  logic [C_NUM_CHANNELS-1:0] i_channel_ack,
    output logic                      o_busy,
    output logic                      o_timeout
);

    // state       | meaning
    // S_IDLE      | no shutdown in progress, waiting for PR request
    // S_REQ       | channel requests out, waiting for all unmasked acks
    // S_DECOUPLED | decouple and PR ack asserted, holding while request stays high
    // S_UNDECOUPLE| one cycle: decouple removed, channel requests still held
    // S_RELEASE   | channel requests dropped, waiting for unmasked acks to fall
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DECOUPLED,
        S_UNDECOUPLE,
        S_RELEASE
    } state_t;

    localparam int           CW      = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
    localparam bit           TO_EN   = (C_TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TC_LAST = CW'(C_TIMEOUT_CYCLES - 1);

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [C_NUM_CHANNELS-1:0] r_mask;
    logic [C_NUM_CHANNELS-1:0] r_channel_req;
    logic                      r_ack;
    logic                      r_decouple;
    logic                      r_busy;
    logic                      r_timeout;

    logic w_done_up;
    logic w_done_dn;
    logic w_expired;

    assign w_done_up = &(i_channel_ack | r_mask);
    assign w_done_dn = ~|(i_channel_ack & ~r_mask);
    assign w_expired = TO_EN && (r_cnt == TC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mask        <= '0;
            r_channel_req <= '0;
            r_ack         <= 1'b0;
            r_decouple    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_pr_shutdown_req) begin
                        r_mask        <= i_channel_mask;
                        r_timeout     <= 1'b0;
                        r_cnt         <= '0;
                        r_channel_req <= ~i_channel_mask;
                        r_busy        <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // abort wins over completion and timeout; fresh count for the release phase
                    if (!i_pr_shutdown_req) begin
                        r_channel_req <= '0;
                        r_cnt         <= '0;
                        r_state       <= S_RELEASE;
                    end else if (w_done_up || w_expired) begin
                        if (!w_done_up) r_timeout <= 1'b1;
                        r_ack      <= 1'b1;
                        r_decouple <= 1'b1;
                        r_state    <= S_DECOUPLED;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DECOUPLED: begin
                    if (!i_pr_shutdown_req) begin
                        r_decouple <= 1'b0;
                        r_state    <= S_UNDECOUPLE;
                    end
                end
                S_UNDECOUPLE: begin
                    r_cnt         <= '0;
                    r_channel_req <= '0;
                    r_ack         <= 1'b0;
                    r_state       <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (w_done_dn || w_expired) begin
                        if (!w_done_dn) r_timeout <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_channel_req <= '0;
                    r_ack         <= 1'b0;
                    r_decouple    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign o_channel_req     = r_channel_req;
    assign o_pr_shutdown_ack = r_ack;
    assign o_pr_decouple     = r_decouple;
    assign o_busy            = r_busy;
    assign o_timeout         = r_timeout;

endmodule

// File: tb/tb_pr_shutdown_ctrl.sv
// Directed bench for pr_shutdown_ctrl: expected output vectors are queued as each
// step is driven and popped/compared one clock later, just after the edge.
module tb_pr_shutdown_ctrl;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pr_req = 1'b0;
    logic         pr_ack;
    logic         decouple;
    logic [N-1:0] mask = '0;
    logic [N-1:0] creq;
    logic [N-1:0] cack = '0;
    logic         busy;
    logic         tmo;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    pr_shutdown_ctrl #(
        .C_NUM_CHANNELS  (N),
        .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_pr_shutdown_req(pr_req),
        .o_pr_shutdown_ack(pr_ack),
        .o_pr_decouple    (decouple),
        .i_channel_mask   (mask),
        .o_channel_req    (creq),
        .i_channel_ack    (cack),
        .o_busy           (busy),
        .o_timeout        (tmo)
    );

    always #5 clk = ~clk;

    // {channel_req, pr_shutdown_ack, pr_decouple, busy, timeout}
    function automatic logic [7:0] ev(input logic [3:0] r, input logic a, input logic d,
                                      input logic b, input logic t);
        return {r, a, d, b, t};
    endfunction

    task automatic compare_front();
        exp_t       e;
        logic [7:0] obs;
        e   = sb.pop_front();
        obs = {creq, pr_ack, decouple, busy, tmo};
        n_assert++;
        assert (obs === e.val)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] val);
        sb.push_back('{tag, val});
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_now(input string tag, input logic [7:0] val);
        sb.push_back('{tag, val});
        compare_front();
    endtask

    initial begin
        #2;
        check_now("reset", ev(4'h0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step("idle", ev(4'h0, 0, 0, 0, 0));

        // nominal: acks arrive one at a time, decouple one cycle after the last
        pr_req = 1'b1;
        step("s1_req", ev(4'hF, 0, 0, 1, 0));
        cack = 4'b0001; step("s1_ack0", ev(4'hF, 0, 0, 1, 0));
        cack = 4'b0011; step("s1_ack1", ev(4'hF, 0, 0, 1, 0));
        cack = 4'b0111; step("s1_ack2", ev(4'hF, 0, 0, 1, 0));
        step("s1_wait", ev(4'hF, 0, 0, 1, 0));
        cack = 4'b1111; step("s1_decoupled", ev(4'hF, 1, 1, 1, 0));
        step("s1_hold", ev(4'hF, 1, 1, 1, 0));
        cack = 4'b1101; step("s1_ackdrop_ignored", ev(4'hF, 1, 1, 1, 0));
        cack = 4'b1111;
        pr_req = 1'b0;  step("s1_undecouple", ev(4'hF, 1, 0, 1, 0));
        step("s1_release", ev(4'h0, 0, 0, 1, 0));
        step("s1_release_wait", ev(4'h0, 0, 0, 1, 0));
        cack = 4'b0000; step("s1_idle", ev(4'h0, 0, 0, 0, 0));

        // masked channels: never requested, their acks ignored both ways
        mask = 4'b1010; pr_req = 1'b1;
        step("s2_req", ev(4'h5, 0, 0, 1, 0));
        mask = 4'b0000; step("s2_mask_latched", ev(4'h5, 0, 0, 1, 0));
        cack = 4'b0001; step("s2_ack0", ev(4'h5, 0, 0, 1, 0));
        cack = 4'b0101; step("s2_decoupled", ev(4'h5, 1, 1, 1, 0));
        pr_req = 1'b0;  step("s2_undecouple", ev(4'h5, 1, 0, 1, 0));
        cack = 4'b1010; step("s2_release", ev(4'h0, 0, 0, 1, 0));
        step("s2_idle_masked_acks", ev(4'h0, 0, 0, 0, 0));
        cack = 4'b0000;

        // timeout: channel 3 never acks, exactly 16 cycles in REQ
        cack = 4'b0111; pr_req = 1'b1;
        step("s3_req", ev(4'hF, 0, 0, 1, 0));
        for (int i = 1; i < TO; i++) step("s3_req_wait", ev(4'hF, 0, 0, 1, 0));
        step("s3_timeout", ev(4'hF, 1, 1, 1, 1));
        pr_req = 1'b0;  step("s3_undecouple", ev(4'hF, 1, 0, 1, 1));
        step("s3_release", ev(4'h0, 0, 0, 1, 1));
        cack = 4'b0000; step("s3_idle_sticky", ev(4'h0, 0, 0, 0, 1));
        pr_req = 1'b1;  step("s3_timeout_cleared", ev(4'hF, 0, 0, 1, 0));

        // abort from REQ with partial acks; re-request during RELEASE waits for IDLE
        cack = 4'b0011; step("s4_partial", ev(4'hF, 0, 0, 1, 0));
        pr_req = 1'b0;  step("s4_abort", ev(4'h0, 0, 0, 1, 0));
        pr_req = 1'b1;  step("s4_rereq_ignored", ev(4'h0, 0, 0, 1, 0));
        cack = 4'b0000; step("s4_idle", ev(4'h0, 0, 0, 0, 0));
        step("s4_rereq_taken", ev(4'hF, 0, 0, 1, 0));

        // reset mid-DECOUPLED clears outputs asynchronously
        cack = 4'b1111; step("s5_decoupled", ev(4'hF, 1, 1, 1, 0));
        #2 rst_n = 1'b0;
        #1 check_now("s5_async_reset", ev(4'h0, 0, 0, 0, 0));
        cack = 4'b0000; pr_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("s5_idle", ev(4'h0, 0, 0, 0, 0));
        pr_req = 1'b1;  step("s5_req", ev(4'hF, 0, 0, 1, 0));
        cack = 4'b1111; step("s5_decoupled2", ev(4'hF, 1, 1, 1, 0));
        pr_req = 1'b0;  step("s5_undecouple", ev(4'hF, 1, 0, 1, 0));
        cack = 4'b0000; step("s5_release", ev(4'h0, 0, 0, 1, 0));
        step("s5_idle2", ev(4'h0, 0, 0, 0, 0));

        // all channels masked: REQ and RELEASE each last one cycle
        mask = 4'b1111; pr_req = 1'b1;
        step("s6_req", ev(4'h0, 0, 0, 1, 0));
        step("s6_decoupled", ev(4'h0, 1, 1, 1, 0));
        pr_req = 1'b0;  step("s6_undecouple", ev(4'h0, 1, 0, 1, 0));
        step("s6_release", ev(4'h0, 0, 0, 1, 0));
        step("s6_idle", ev(4'h0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pr_shutdown_ctrl.md
Name: pr_shutdown_ctrl

Overview:
- Upstream sequencer for a bank of AXI-Stream PR shutdown stages.
- Takes one shutdown request from the partial-reconfiguration controller and fans it out as per-channel shutdown_req.
- Collects each channel's shutdown_ack, then asserts a global decouple and acknowledge to the PR controller.
- On release, un-decouples first, then drops channel requests, so streams resume only after the decouple is removed.

Parameters:
- C_NUM_CHANNELS, 4: number of downstream shutdown stages (1..32).
- C_TIMEOUT_CYCLES, 65536: cycles to wait for acks per phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pr_shutdown_req  in  1  level request from PR controller.
- pr_shutdown_ack  out  1  all unmasked channels quiesced (or forced by timeout).
- pr_decouple  out  1  decouple enable to the PR isolation logic.
- channel_mask  in  C_NUM_CHANNELS  1 = ignore channel's ack; sampled on entry to REQ.
- channel_req  out  C_NUM_CHANNELS  to each stage's shutdown_req.
- channel_ack  in  C_NUM_CHANNELS  from each stage's shutdown_ack.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky flag: a phase ended by timeout.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0: channel_req, pr_shutdown_ack, pr_decouple, busy, timeout.
  - Counter 0, mask register 0.
- All outputs are registered.
- Counter width: clog2(C_TIMEOUT_CYCLES+1).
- Definitions:
  - done_up = &(channel_ack | mask_q)
  - done_dn = ~|(channel_ack & ~mask_q)
- IDLE:
  - On pr_shutdown_req=1: mask_q <= channel_mask, timeout <= 0, counter <= 0, go REQ.
  - Outputs in REQ: channel_req = ~mask_q (masked channels never requested), busy = 1.
  - Latency: req sampled high at cycle N gives channel_req high at N+1.
- REQ:
  - If pr_shutdown_req=0 (abort): go RELEASE.
  - Else if done_up: go DECOUPLED.
  - Else if C_TIMEOUT_CYCLES != 0 and counter == C_TIMEOUT_CYCLES-1: timeout <= 1, go DECOUPLED (forced).
  - Else counter increments.
  - Abort has priority over done and timeout in the same cycle.
- DECOUPLED:
  - pr_decouple = 1, pr_shutdown_ack = 1, channel_req held.
  - Latency: done_up seen at cycle K gives ack and decouple high at K+1.
  - Stay while pr_shutdown_req=1.
  - On 0: go UNDECOUPLE.
- UNDECOUPLE (one cycle):
  - pr_decouple = 0, pr_shutdown_ack = 1, channel_req still held.
  - Counter <= 0, go RELEASE.
- RELEASE:
  - channel_req = 0, pr_shutdown_ack = 0, pr_decouple = 0.
  - Wait for done_dn, then go IDLE.
  - Same timeout rule as REQ: on expiry set timeout and go IDLE.
  - pr_shutdown_req re-asserted during RELEASE is ignored until IDLE; it is then taken on the next cycle.
- Vacuous cases:
  - All channels masked: done_up is true immediately, REQ lasts exactly one cycle.
  - RELEASE likewise completes in one cycle.
- Ack that drops while in DECOUPLED: ignored (no re-handshake).
- timeout remains set until the next IDLE->REQ transition.
- Reset asserted mid-sequence: outputs clear asynchronously.
  - channel_req drops without the un-decouple ordering; this is acceptable because the downstream stages are reset by the same rst_n.

Test Plan:
- N=4, mask=0, req rises at cycle 10, acks rise at cycles 12/13/15/20:
  - channel_req=4'hF at cycle 11.
  - pr_shutdown_ack and pr_decouple = 1 at cycle 21.
  - timeout = 0.
- Release from DECOUPLED, req falls at cycle 30:
  - pr_decouple = 0 at 31 while channel_req = 4'hF and ack = 1 at 31.
  - channel_req = 0 at 32.
  - Acks fall at 34, so busy = 0 at 35.
- mask=4'b1010, only acks 0 and 2 respond:
  - channel_req = 4'b0101.
  - Decouple asserted one cycle after both acks high.
- C_TIMEOUT_CYCLES=16, channel 3 never acks:
  - Exactly 16 cycles in REQ, then DECOUPLED with timeout = 1.
  - timeout clears at the next request.
- Abort: req drops in REQ while acks are incomplete:
  - pr_decouple never asserts.
  - channel_req = 0 the next cycle; return to IDLE after acks fall.
- Reset mid-DECOUPLED:
  - All outputs 0 within the reset cycle (asynchronously).
  - After release, a new req follows the nominal timing of the first scenario.
